// File: rtl/dmux4way16_dist.sv
// Demultiplexes one write stream into four registered lanes (a..d), steered by sel or a round-robin pointer.
// Accepted data visible 1 cycle later; in_ready is combinational and drops only when the target lane is full and not acked.
module dmux4way16_dist #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       sel,
   input  logic             auto,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ack,
   output logic [1:0]       ptr,
   output logic [2:0]       count
);

   logic [WIDTH-1:0] r_lane [4];
   logic [3:0]       r_valid;
   logic [1:0]       r_ptr;
   logic [2:0]       r_count;

   logic [1:0]       w_target;
   logic             w_in_ready;
   logic             w_accept;
   logic [3:0]       w_valid_nxt;
   logic [2:0]       w_count_nxt;

   assign w_target   = auto ? r_ptr : sel;
   assign w_in_ready = !r_valid[w_target] | out_ack[w_target];
   assign w_accept   = in_valid & w_in_ready;

   // Acks clear first, then an accept re-sets its lane, so a same-cycle refill wins.
   always_comb begin
      w_valid_nxt = r_valid & ~out_ack;
      if (w_accept) begin
         w_valid_nxt[w_target] = 1'b1;
      end
      w_count_nxt = 3'($countones(w_valid_nxt));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            r_lane[i] <= '0;
         end
         r_valid <= 4'b0000;
         r_ptr   <= 2'd0;
         r_count <= 3'd0;
      end else begin
         if (w_accept) begin
            r_lane[w_target] <= in;
         end
         if (w_accept & auto) begin
            r_ptr <= r_ptr + 2'd1;
         end
         r_valid <= w_valid_nxt;
         r_count <= w_count_nxt;
      end
   end

   assign in_ready  = w_in_ready;
   assign a         = r_lane[0];
   assign b         = r_lane[1];
   assign c         = r_lane[2];
   assign d         = r_lane[3];
   assign out_valid = r_valid;
   assign ptr       = r_ptr;
   assign count     = r_count;

endmodule

// File: tb/tb_dmux4way16_dist.sv
// Directed bench for dmux4way16_dist: hand-computed expectations checked with immediate assertions.
module tb_dmux4way16_dist;

   logic        clk;
   logic        reset;
   logic [15:0] in;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  sel;
   logic        auto;
   logic [15:0] a, b, c, d;
   logic [3:0]  out_valid;
   logic [3:0]  out_ack;
   logic [1:0]  ptr;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   dmux4way16_dist #(.WIDTH(16)) dut (
      .clock(clk), .reset(reset), .in(in), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .auto(auto), .a(a), .b(b), .c(c), .d(d),
      .out_valid(out_valid), .out_ack(out_ack), .ptr(ptr), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_sel(input logic [1:0] s, input logic [15:0] v);
      auto = 1'b0; sel = s; in = v; in_valid = 1'b1;
      tick();
   endtask

   initial begin
      reset = 1'b1; in = '0; in_valid = 1'b0; sel = 2'd0; auto = 1'b0; out_ack = 4'b0000;
      tick();
      tick();
      chk("rst_a", a, 16'h0);
      chk("rst_d", d, 16'h0);
      chk("rst_valid", 16'(out_valid), 16'h0);
      chk("rst_ptr", 16'(ptr), 16'h0);
      chk("rst_count", 16'(count), 16'h0);
      chk("rst_ready", 16'(in_ready), 16'h1);
      reset = 1'b0;

      // Explicit writes
      write_sel(2'd0, 16'h1234);
      chk("w0_a", a, 16'h1234);
      chk("w0_valid", 16'(out_valid), 16'h1);
      chk("w0_count", 16'(count), 16'h1);
      write_sel(2'd1, 16'h9876);
      write_sel(2'd2, 16'hAAAA);
      write_sel(2'd3, 16'h5555);
      chk("w_a", a, 16'h1234);
      chk("w_b", b, 16'h9876);
      chk("w_c", c, 16'hAAAA);
      chk("w_d", d, 16'h5555);
      chk("w_valid", 16'(out_valid), 16'hF);
      chk("w_count", 16'(count), 16'h4);
      chk("w_ptr", 16'(ptr), 16'h0);

      // Full-lane stall, then ack plus refill in the same cycle
      sel = 2'd1; in = 16'hFFFF; in_valid = 1'b1; out_ack = 4'b0000;
      #1;
      chk("stall_ready", 16'(in_ready), 16'h0);
      tick();
      chk("stall_b", b, 16'h9876);
      out_ack = 4'b0010;
      #1;
      chk("ack_ready", 16'(in_ready), 16'h1);
      tick();
      out_ack = 4'b0000; in_valid = 1'b0;
      chk("refill_b", b, 16'hFFFF);
      chk("refill_valid", 16'(out_valid), 16'hF);
      chk("refill_count", 16'(count), 16'h4);

      // Round-robin with wrap, all lanes acked every cycle
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rr_ptr0", 16'(ptr), 16'h0);
      auto = 1'b1; out_ack = 4'b1111; in_valid = 1'b1;
      in = 16'h0001; tick();
      chk("rr_a1", a, 16'h0001);
      chk("rr_ptr1", 16'(ptr), 16'h1);
      in = 16'h0002; tick();
      chk("rr_b2", b, 16'h0002);
      chk("rr_ptr2", 16'(ptr), 16'h2);
      in = 16'h0003; tick();
      chk("rr_c3", c, 16'h0003);
      chk("rr_ptr3", 16'(ptr), 16'h3);
      in = 16'h0004; tick();
      chk("rr_d4", d, 16'h0004);
      chk("rr_ptr_wrap", 16'(ptr), 16'h0);
      in = 16'h0005; tick();
      chk("rr_a5", a, 16'h0005);
      chk("rr_ptr5", 16'(ptr), 16'h1);
      chk("rr_valid", 16'(out_valid), 16'h1);
      chk("rr_count", 16'(count), 16'h1);

      // Build ptr=2 with c full and d empty; explicit write must not move ptr
      out_ack = 4'b0000;
      in = 16'h0B0B; tick();
      chk("ns_b", b, 16'h0B0B);
      chk("ns_ptr_pre", 16'(ptr), 16'h2);
      write_sel(2'd2, 16'h0C0C);
      chk("ns_ptr_sel", 16'(ptr), 16'h2);
      chk("ns_valid_pre", 16'(out_valid), 16'h7);
      auto = 1'b1; in = 16'hDDDD; in_valid = 1'b1;
      #1;
      chk("ns_ready", 16'(in_ready), 16'h0);
      tick();
      chk("ns_ptr", 16'(ptr), 16'h2);
      chk("ns_d_held", d, 16'h0004);
      chk("ns_c", c, 16'h0C0C);
      chk("ns_valid", 16'(out_valid), 16'h7);

      // Ack edge cases
      in_valid = 1'b0; out_ack = 4'b0010;
      tick();
      chk("ack_valid_0101", 16'(out_valid), 16'h5);
      chk("ack_count2", 16'(count), 16'h2);
      out_ack = 4'b1111;
      tick();
      chk("ackall_valid", 16'(out_valid), 16'h0);
      chk("ackall_count", 16'(count), 16'h0);
      chk("ackall_a_held", a, 16'h0005);
      out_ack = 4'b1000;
      tick();
      chk("ackempty_valid", 16'(out_valid), 16'h0);
      chk("ackempty_count", 16'(count), 16'h0);
      chk("ackempty_ptr", 16'(ptr), 16'h2);
      out_ack = 4'b0000;

      // Reset overriding a pending write and an ack
      write_sel(2'd0, 16'h1111);
      write_sel(2'd1, 16'h2222);
      write_sel(2'd2, 16'h3333);
      write_sel(2'd3, 16'h4444);
      chk("pre_rst_count", 16'(count), 16'h4);
      reset = 1'b1; in_valid = 1'b1; sel = 2'd3; in = 16'h5555; out_ack = 4'b0001;
      tick();
      reset = 1'b0; in_valid = 1'b0; out_ack = 4'b0000;
      chk("mid_a", a, 16'h0);
      chk("mid_b", b, 16'h0);
      chk("mid_c", c, 16'h0);
      chk("mid_d", d, 16'h0);
      chk("mid_valid", 16'(out_valid), 16'h0);
      chk("mid_ptr", 16'(ptr), 16'h0);
      chk("mid_count", 16'(count), 16'h0);
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s); auto = 1'b0;
         #1;
         chk($sformatf("post_rst_ready_sel%0d", s), 16'(in_ready), 16'h1);
      end
      auto = 1'b1;
      #1;
      chk("post_rst_ready_auto", 16'(in_ready), 16'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmux4way16_dist.md
Name: dmux4way16_dist

Overview:
- Write-side counterpart of the 4-way 16-bit selector: one 16-bit input stream is demultiplexed into four registered output lanes (a, b, c, d).
- Each lane holds its word with a valid flag until the consumer acknowledges it.
- The destination lane comes either from an explicit 2-bit select or from an internal round-robin pointer.
- Sits in front of four consumers that each need their own 16-bit slot. It is the building block for RAM-style write fan-out.

Parameters:
- WIDTH, 16, data width of the input and of each lane.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  write data.
- in_valid  input  1  write request this cycle.
- in_ready  output  1  target lane can accept (combinational).
- sel  input  2  explicit lane select: 0=a, 1=b, 2=c, 3=d.
- auto  input  1  1 = target is the round-robin pointer; 0 = target is sel.
- a, b, c, d  output  WIDTH  registered lane data.
- out_valid  output  4  per-lane full flag; bit0=a … bit3=d.
- out_ack  input  4  per-lane consume strobe; bit0=a … bit3=d.
- ptr  output  2  current round-robin pointer.
- count  output  3  number of lanes currently valid (0..4).

Behaviour:
- Reset: synchronous, takes effect on the next rising edge whenever reset=1. It overrides in_valid and out_ack in the same cycle. It sets:
  - a=b=c=d=0
  - out_valid=0000
  - ptr=0
  - count=0
- Target selection:
  - target = auto ? ptr : sel.
  - Re-evaluated every cycle; there is no lock while in_valid is held.
- Ready: in_ready = !out_valid[target] | out_ack[target]. It is combinational from auto, sel, ptr, out_valid and out_ack.
- Accept: when in_valid & in_ready at a rising edge:
  - the target lane's data <= in;
  - out_valid[target] <= 1.
  - Latency is 1 cycle: the lane shows the new data and valid on the cycle after acceptance.
- Non-target lanes keep their data and valid unchanged. Data is held (not zeroed) after an ack, until it is overwritten.
- Ack:
  - out_ack[i] with out_valid[i]=1 clears out_valid[i] at the edge.
  - out_ack[i] with out_valid[i]=0 is ignored.
  - Acks on several lanes in one cycle are all honoured.
- Simultaneous ack and refill of the same lane: the accept wins. out_valid stays 1, the data becomes the new word, and count is unchanged.
- Round-robin pointer:
  - Advances ptr <= ptr+1 only on an accepted write while auto=1.
  - Wraps 3 -> 0.
  - Writes with auto=0 do not move ptr; ptr persists across mode changes.
- Auto-mode stall: if the lane at ptr is full and not being acked, in_ready=0. The block never skips to another free lane.
- count:
  - Registered popcount of out_valid, updated at the same edge as out_valid.
  - It can rise by 1, fall by up to 4, or both in one cycle (the net is applied).
- in_valid=0: no lane changes except acks; ptr holds.
- Reset during a stalled or pending write: the write is dropped. After reset, in_ready=1 for every target.

Test Plan:
- Reset, then explicit writes with auto=0:
  - stimulus: sel=0 in=0x1234, sel=1 in=0x9876, sel=2 in=0xAAAA, sel=3 in=0x5555, one per cycle.
  - response: a=0x1234, b=0x9876, c=0xAAAA, d=0x5555; out_valid=1111, count=4; ptr=0 throughout.
- Full-lane stall:
  - stimulus: with lane b full, sel=1 in=0xFFFF, in_valid=1, no ack.
  - response: in_ready=0 and b stays 0x9876.
  - stimulus: then out_ack=0010 for one cycle.
  - response: in_ready=1 that cycle; b=0xFFFF next cycle; out_valid bit1 stays 1; count stays 4.
- Round-robin with wrap:
  - stimulus: reset, auto=1, write 0x0001..0x0005 on consecutive cycles, out_ack=1111 held.
  - response: a=0x0001, b=0x0002, c=0x0003, d=0x0004, then a=0x0005. ptr goes 0,1,2,3,0,1.
- Auto-mode no-skip:
  - stimulus: auto=1, ptr=2, lane c full, lane d empty, in_valid=1, no ack.
  - response: in_ready=0, ptr stays 2, d unchanged.
- Ack edge cases:
  - stimulus: out_ack=1111 with out_valid=0101.
  - response: out_valid=0000, count 2->0.
  - stimulus: out_ack on an empty lane.
  - response: no change.
- Reset mid-operation:
  - stimulus: reset=1 with in_valid=1, sel=3, in=0x5555, out_ack=0001, all lanes full.
  - response: the next cycle shows a=b=c=d=0, out_valid=0000, ptr=0, count=0, and d not written.
